// File: rtl/draw_border_flash_pkg.sv
// Shared display definitions: colour constants, active-area defaults and the
// state type used by every blink/flash sequencer in the playfield.
package draw_border_flash_pkg;

  localparam int unsigned RGB_W = 3;

  localparam logic [RGB_W-1:0] COLOR_WHITE = 3'b111;
  localparam logic [RGB_W-1:0] COLOR_RED   = 3'b100;
  localparam logic [RGB_W-1:0] COLOR_BLACK = 3'b000;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;

  typedef enum logic [1:0] {
    FLASH_IDLE = 2'd0,
    FLASH_ON   = 2'd1,
    FLASH_OFF  = 2'd2
  } flash_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/draw_border_flash_flash_sequencer.sv
// Frame-synchronous flash sequencer: after a request, alternates ON/OFF phases
// of HALF_FRAMES frames each for N_FLASH blink pairs, then returns to idle.
//
//   state      | meaning
//   FLASH_IDLE | no sequence running, frame ticks ignored
//   FLASH_ON   | flash-colour half period, counting frame ticks
//   FLASH_OFF  | invisible half period, counting ticks and blink pairs
module draw_border_flash_flash_sequencer
  import draw_border_flash_pkg::*;
#(
  parameter int unsigned HALF_FRAMES = 8,
  parameter int unsigned N_FLASH     = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         frame_tick_i,
  input  logic         flash_req_i,
  output flash_state_e state_o,
  output logic         flash_busy_o
);

  localparam int unsigned FW = cnt_width(HALF_FRAMES);
  localparam int unsigned NW = cnt_width(N_FLASH);

  localparam logic [FW-1:0] FRAME_LAST = FW'(HALF_FRAMES - 1);
  localparam logic [NW-1:0] FLASH_LAST = NW'(N_FLASH - 1);

  flash_state_e  state_q;
  logic [FW-1:0] frame_cnt_q;
  logic [NW-1:0] flash_cnt_q;
  logic          busy_q;

  // Sequencer FSM: a request always (re)starts from ON with cleared counters
  // and takes priority over a coincident frame tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FLASH_IDLE;
      frame_cnt_q <= '0;
      flash_cnt_q <= '0;
      busy_q      <= 1'b0;
    end else if (flash_req_i) begin
      state_q     <= FLASH_ON;
      frame_cnt_q <= '0;
      flash_cnt_q <= '0;
      busy_q      <= 1'b1;
    end else if (frame_tick_i) begin
      case (state_q)
        FLASH_ON: begin
          if (frame_cnt_q == FRAME_LAST) begin
            state_q     <= FLASH_OFF;
            frame_cnt_q <= '0;
          end else begin
            frame_cnt_q <= frame_cnt_q + 1'b1;
          end
        end
        FLASH_OFF: begin
          if (frame_cnt_q == FRAME_LAST) begin
            frame_cnt_q <= '0;
            if (flash_cnt_q == FLASH_LAST) begin
              state_q     <= FLASH_IDLE;
              flash_cnt_q <= '0;
              busy_q      <= 1'b0;
            end else begin
              state_q     <= FLASH_ON;
              flash_cnt_q <= flash_cnt_q + 1'b1;
            end
          end else begin
            frame_cnt_q <= frame_cnt_q + 1'b1;
          end
        end
        FLASH_IDLE: begin
          state_q <= FLASH_IDLE;
        end
        default: begin
          state_q     <= FLASH_IDLE;
          frame_cnt_q <= '0;
          flash_cnt_q <= '0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign state_o      = state_q;
  assign flash_busy_o = busy_q;

endmodule

// File: rtl/draw_border_flash.sv
// Playfield border generator with flash overlay. The border is the outermost
// ring of tiles; output is registered, one clock behind x_pos/y_pos.
module draw_border_flash
  import draw_border_flash_pkg::*;
#(
  parameter int unsigned      BIT          = 10,
  parameter int unsigned      H_ACTIVE     = H_ACTIVE_DEF,
  parameter int unsigned      V_ACTIVE     = V_ACTIVE_DEF,
  parameter int unsigned      THICK_LOG2   = 4,
  parameter logic [RGB_W-1:0] COLOR_NORMAL = COLOR_WHITE,
  parameter logic [RGB_W-1:0] COLOR_FLASH  = COLOR_RED,
  parameter int unsigned      HALF_FRAMES  = 8,
  parameter int unsigned      N_FLASH      = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BIT-1:0]   x_pos,
  input  logic [BIT-1:0]   y_pos,
  input  logic             frame_tick,
  input  logic             flash_req,
  output logic             border_active,
  output logic [RGB_W-1:0] rgb,
  output logic             flash_busy
);

  localparam logic [BIT-1:0] X_LAST_TILE = BIT'((H_ACTIVE - 1) >> THICK_LOG2);
  localparam logic [BIT-1:0] Y_LAST_TILE = BIT'((V_ACTIVE - 1) >> THICK_LOG2);

  flash_state_e     seq_state;
  logic [BIT-1:0]   x_tile;
  logic [BIT-1:0]   y_tile;
  logic             hit;
  logic             border_d;
  logic             border_q;
  logic [RGB_W-1:0] rgb_d;
  logic [RGB_W-1:0] rgb_q;

  draw_border_flash_flash_sequencer #(
    .HALF_FRAMES (HALF_FRAMES),
    .N_FLASH     (N_FLASH)
  ) u_flash_sequencer (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick_i (frame_tick),
    .flash_req_i  (flash_req),
    .state_o      (seq_state),
    .flash_busy_o (flash_busy)
  );

  assign x_tile = x_pos >> THICK_LOG2;
  assign y_tile = y_pos >> THICK_LOG2;
  assign hit    = (x_tile == '0) || (x_tile == X_LAST_TILE) ||
                  (y_tile == '0) || (y_tile == Y_LAST_TILE);

  // Select visibility and colour from the current flash phase.
  always_comb begin
    border_d = 1'b0;
    rgb_d    = COLOR_BLACK;
    case (seq_state)
      FLASH_IDLE: begin
        border_d = hit;
        rgb_d    = hit ? COLOR_NORMAL : COLOR_BLACK;
      end
      FLASH_ON: begin
        border_d = hit;
        rgb_d    = hit ? COLOR_FLASH : COLOR_BLACK;
      end
      default: begin
        border_d = 1'b0;
        rgb_d    = COLOR_BLACK;
      end
    endcase
  end

  // Output register giving the fixed one-clock pixel latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      border_q <= 1'b0;
      rgb_q    <= COLOR_BLACK;
    end else begin
      border_q <= border_d;
      rgb_q    <= rgb_d;
    end
  end

  assign border_active = border_q;
  assign rgb           = rgb_q;

endmodule

// File: tb/tb_draw_border_flash.sv
// Randomised bench for draw_border_flash against a frame-count reference model.
module tb_draw_border_flash;

  localparam int BIT     = 10;
  localparam int H_ACT   = 640;
  localparam int V_ACT   = 480;
  localparam int TL      = 4;
  localparam int HALF    = 2;
  localparam int NF      = 2;
  localparam int TILE    = 1 << TL;
  localparam int SEQ_LEN = 2 * HALF * NF;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [BIT-1:0] x_pos;
  logic [BIT-1:0] y_pos;
  logic           frame_tick;
  logic           flash_req;
  logic           border_active;
  logic [2:0]     rgb;
  logic           flash_busy;

  int errors = 0;
  int checks = 0;

  // Reference: ticks counted since the last request; phase = ticks / HALF.
  int m_ticks = 0;
  bit m_busy  = 1'b0;

  always #5 clk = ~clk;

  draw_border_flash #(
    .BIT          (BIT),
    .H_ACTIVE     (H_ACT),
    .V_ACTIVE     (V_ACT),
    .THICK_LOG2   (TL),
    .COLOR_NORMAL (3'b111),
    .COLOR_FLASH  (3'b100),
    .HALF_FRAMES  (HALF),
    .N_FLASH      (NF)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .x_pos         (x_pos),
    .y_pos         (y_pos),
    .frame_tick    (frame_tick),
    .flash_req     (flash_req),
    .border_active (border_active),
    .rgb           (rgb),
    .flash_busy    (flash_busy)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_hit(input int x, input int y);
    return (x / TILE == 0) || (x / TILE == (H_ACT - 1) / TILE) ||
           (y / TILE == 0) || (y / TILE == (V_ACT - 1) / TILE);
  endfunction

  function automatic int rand_x();
    case ($urandom_range(0, 3))
      0:       return $urandom_range(0, 31);
      1:       return $urandom_range(600, H_ACT - 1);
      default: return $urandom_range(0, H_ACT - 1);
    endcase
  endfunction

  function automatic int rand_y();
    case ($urandom_range(0, 3))
      0:       return $urandom_range(0, 31);
      1:       return $urandom_range(440, V_ACT - 1);
      default: return $urandom_range(0, V_ACT - 1);
    endcase
  endfunction

  // One clock: present pixel and controls, then compare the registered result.
  task automatic step(input int x, input int y, input bit req, input bit tick);
    bit h;
    bit visible;
    int exp_ba;
    int exp_rgb;
    x_pos      = BIT'(x);
    y_pos      = BIT'(y);
    flash_req  = req;
    frame_tick = tick;
    h       = ref_hit(x, y);
    visible = !m_busy || (((m_ticks / HALF) % 2) == 0);
    exp_ba  = (h && visible) ? 1 : 0;
    exp_rgb = (exp_ba == 0) ? 0 : (m_busy ? 4 : 7);
    @(posedge clk);
    #1;
    if (req) begin
      m_busy  = 1'b1;
      m_ticks = 0;
    end else if (tick && m_busy) begin
      m_ticks++;
      if (m_ticks == SEQ_LEN) begin
        m_busy  = 1'b0;
        m_ticks = 0;
      end
    end
    chk("border_active", border_active, exp_ba);
    chk("rgb", rgb, exp_rgb);
    chk("flash_busy", flash_busy, m_busy);
    flash_req  = 1'b0;
    frame_tick = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    x_pos      = '0;
    y_pos      = '0;
    frame_tick = 1'b0;
    flash_req  = 1'b0;

    // Reset values with a border pixel on the inputs
    #12;
    chk("rst_border_active", border_active, 0);
    chk("rst_rgb", rgb, 0);
    chk("rst_flash_busy", flash_busy, 0);
    release_reset();
    step(0, 0, 0, 0);

    // Tile edges
    step(15, 200, 0, 0);
    step(16, 200, 0, 0);
    step(623, 200, 0, 0);
    step(624, 200, 0, 0);
    step(639, 200, 0, 0);
    step(200, 15, 0, 0);
    step(200, 16, 0, 0);
    step(200, 463, 0, 0);
    step(200, 464, 0, 0);
    step(200, 479, 0, 0);

    // Full flash sequence at (0,0) with random pixels interleaved
    step(0, 0, 1, 0);
    for (int t = 0; t < SEQ_LEN; t++) begin
      step(0, 0, 0, 0);
      step(rand_x(), rand_y(), 0, 0);
      step(0, 0, 0, 1);
    end
    step(0, 0, 0, 0);
    chk("seq_done_rgb", rgb, 7);
    chk("seq_done_busy", flash_busy, 0);

    // Retrigger during OFF, then a full sequence is needed again
    step(0, 0, 1, 0);
    for (int t = 0; t < HALF; t++) step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("in_off_border", border_active, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    chk("retrig_rgb", rgb, 4);
    for (int t = 0; t < SEQ_LEN - 1; t++) step(0, 0, 0, 1);
    chk("retrig_still_busy", flash_busy, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("retrig_idle_busy", flash_busy, 0);

    // Simultaneous request and tick from idle: the tick is not counted
    step(0, 0, 1, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("simul_still_on", rgb, 4);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("simul_now_off", border_active, 0);

    // Reset in the middle of an ON phase
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_border_active", border_active, 0);
    chk("midrst_rgb", rgb, 0);
    chk("midrst_busy", flash_busy, 0);
    m_busy  = 1'b0;
    m_ticks = 0;
    release_reset();
    step(0, 0, 0, 0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(rand_x(), rand_y(), ($urandom_range(0, 39) == 0), ($urandom_range(0, 5) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/draw_border_flash.md
Name: draw_border_flash

Overview:
- Parametrised, registered successor of the playfield border generator.
- Decides per pixel whether the border tile grid covers (x_pos, y_pos) and which 3-bit colour to drive.
- Adds a frame-synchronous flash sequencer: a pulse on flash_req (collision or game-over from game logic) makes the border alternate between flash colour and invisible for a programmable number of blinks, then return to normal.
- Sits between the VGA timing counters and the pixel colour mux.

Parameters:
- BIT, 10, width of x_pos/y_pos.
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines per frame.
- THICK_LOG2, 4, border thickness as log2 of the tile size (tile = 2^THICK_LOG2 pixels).
- COLOR_NORMAL, 3'b111, border colour when idle.
- COLOR_FLASH, 3'b100, border colour in the flash-on phase.
- HALF_FRAMES, 8, frames per flash half-period (≥1).
- N_FLASH, 3, number of on/off blink pairs per request (≥1).

Ports:
- clk  input  1  pixel clock.
- rst_n  input  1  asynchronous active-low reset.
- x_pos  input  BIT  current pixel column.
- y_pos  input  BIT  current pixel row.
- frame_tick  input  1  one-cycle pulse per frame, from timing generator at start of vblank.
- flash_req  input  1  one-cycle pulse requesting a flash sequence.
- border_active  output  1  registered; border covers the pixel presented one cycle earlier.
- rgb  output  3  registered border colour; valid when border_active=1, else 3'b000.
- flash_busy  output  1  high while a flash sequence runs.

Behaviour:
- Reset (rst_n low, asynchronous):
  - border_active=0, rgb=3'b000, flash_busy=0.
  - state=IDLE, frame_cnt=0, flash_cnt=0.
- Hit test (combinational, then registered):
  - hit = x_pos>>THICK_LOG2 equals 0 or (H_ACTIVE-1)>>THICK_LOG2, or y_pos>>THICK_LOG2 equals 0 or (V_ACTIVE-1)>>THICK_LOG2.
  - Comparisons are unsigned, BIT wide.
- Latency: exactly 1 clk from x_pos/y_pos to border_active/rgb. The caller delays its other layers by 1 to match.
- Output by state:
  - IDLE: border_active=hit, rgb=hit?COLOR_NORMAL:0.
  - ON: border_active=hit, rgb=hit?COLOR_FLASH:0.
  - OFF: border_active=0, rgb=0.
- FSM states: IDLE, ON, OFF. flash_busy=(state!=IDLE).
- IDLE:
  - flash_req -> ON, frame_cnt=0, flash_cnt=0.
  - frame_tick is ignored.
- ON:
  - Each frame_tick increments frame_cnt.
  - On a tick with frame_cnt==HALF_FRAMES-1 -> OFF, frame_cnt=0.
- OFF:
  - Same frame counting as ON.
  - At terminal count: if flash_cnt==N_FLASH-1 -> IDLE, else flash_cnt+1 and -> ON.
- Retrigger: flash_req while busy restarts the sequence (-> ON, both counters 0).
- Simultaneous flash_req and frame_tick: the request wins and the tick is not counted.
- State changes take effect on the cycle after the frame_tick edge. Because frame_tick fires in vblank, no visible frame mixes phases.
- Counter widths: $clog2(HALF_FRAMES) and $clog2(N_FLASH), minimum 1 bit. Counters never exceed their terminal values.
- Reset mid-sequence aborts to IDLE immediately. The first pixel after release shows normal colour.
- Sequence length: 2*HALF_FRAMES*N_FLASH frame_ticks from request to return to IDLE.

Decomposition:
- Shared display package holds:
  - the RGB width constant (3);
  - the colour constants (white, red, black);
  - the H_ACTIVE/V_ACTIVE defaults;
  - the FSM state enum typedef for flash sequencers (IDLE/ON/OFF), reused by the food/snake blink logic.
- Sub-module flash_sequencer: FSM, counters, flash_busy; inputs frame_tick/flash_req.
- The top level keeps the hit test and output registers.

Test Plan:
- Reset: hold rst_n=0 and drive x=0, y=0 -> border_active=0, rgb=0, flash_busy=0. After release, (0,0) gives border_active=1, rgb=3'b111 one clk later.
- Tile edges with THICK_LOG2=4:
  - x=15 -> 1; x=16 (y=200) -> 0.
  - x=623 -> 0; x=624 -> 1.
  - y=463 (x=200) -> 0; y=464 -> 1.
- Flash sequence, HALF_FRAMES=2, N_FLASH=2: pulse flash_req, then drive frame_ticks.
  - At (0,0): rgb=3'b100 for 2 ticks, then border_active=0 for 2 ticks, repeated once.
  - After tick 8, rgb=3'b111 and flash_busy=0.
- Retrigger: pulse flash_req during the OFF phase -> next cycle state ON, rgb=3'b100. A full 8 ticks are then needed to reach idle.
- Simultaneous: flash_req and frame_tick in the same cycle from IDLE -> ON. 2 further ticks are needed (not 1) to reach OFF.
- Mid-sequence reset: assert rst_n=0 during ON -> outputs 0 asynchronously. After release, (0,0) gives rgb=3'b111 and flash_busy=0.
